hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline control unit that drives the stall (enable) and flush (active-low reset) inputs of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC register.
- Detects three hazards:
  - load-use, between the instruction in ID and the load in EX;
  - control redirect, when pc_sel resolves in EX;
  - memory wait, from the LSU.
- Keeps a small state machine and saturating event counters for debug and performance readout.
- Sits beside the ID/EX register: it consumes that register's EX-side outputs and produces its i_enable_id and i_reset_id.

Parameters:
- CNT_W, 32, width of each saturating performance counter.
- WB_SEL_LOAD, 2'b01, wb_sel encoding that marks a load (write-back from LSU).

Ports:
- i_clk  in  1  pipeline clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_instr_id  in  32  instruction currently in ID.
- i_instr_ex  in  32  instruction currently in EX (instr_ex from ID/EX).
- i_rd_wren_ex  in  1  EX instruction writes rd.
- i_wb_sel_ex  in  2  EX write-back select.
- i_pc_sel_ex  in  1  EX resolved a taken branch or jump.
- i_lsu_busy  in  1  LSU cannot complete this cycle.
- o_pc_enable  out  1  PC register update enable.
- o_enable_if  out  1  IF/ID register enable.
- o_reset_if  out  1  IF/ID flush, active-low.
- o_enable_id  out  1  ID/EX register enable.
- o_reset_id  out  1  ID/EX flush, active-low; ID/EX loads its NOP state.
- o_enable_ex  out  1  EX/MEM register enable.
- o_state  out  2  current FSM state (RUN=0, MEM_WAIT=1, REDIRECT=2).
- o_stall_cnt  out  CNT_W  load-use bubbles inserted.
- o_flush_cnt  out  CNT_W  redirect flushes performed.
- o_memwait_cnt  out  CNT_W  cycles spent frozen on i_lsu_busy.

Behaviour:
- Reset (i_reset=1, asynchronous):
  - state=RUN; all counters 0.
  - While reset is high, outputs are forced: o_pc_enable=0, all o_enable_*=0, o_reset_if=0, o_reset_id=0 (both flushing).
- Control outputs are combinational from state and inputs, taking effect in the same cycle. State and counters are registered on posedge i_clk.
- Field extraction:
  - rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7].
  - ID uses rs1 unless opcode is LUI (0110111), AUIPC (0010111) or JAL (1101111).
  - ID uses rs2 only for opcodes 0110011 (R), 0100011 (S) and 1100011 (B).
- load_use = i_rd_wren_ex & (i_wb_sel_ex==WB_SEL_LOAD) & rd_ex!=0 & ((uses_rs1 & rs1_id==rd_ex) | (uses_rs2 & rs2_id==rd_ex)).
- Default (no hazard): all enables=1, both flushes=1 (inactive).
- Priority, highest first:
  - i_lsu_busy → freeze: o_pc_enable=0, o_enable_if=0, o_enable_id=0, o_enable_ex=0, no flush. Next state=MEM_WAIT.
  - i_pc_sel_ex → redirect: o_pc_enable=1, o_reset_if=0, o_reset_id=0, enables=1. Next state=REDIRECT for one cycle. o_flush_cnt+1.
  - load_use → bubble: o_pc_enable=0, o_enable_if=0, o_reset_id=0, o_enable_ex=1. Next state=RUN. o_stall_cnt+1.
- MEM_WAIT state:
  - Stays while i_lsu_busy; o_memwait_cnt+1 every busy cycle, in any state.
  - When busy falls, the same-cycle priority rules apply and the state follows them.
  - A redirect pending in frozen ID/EX is therefore taken on the first non-busy cycle, exactly once.
- REDIRECT state:
  - Lasts one cycle, during which load_use is ignored because ID holds the flushed NOP.
  - i_lsu_busy still freezes; i_pc_sel_ex still redirects, and the counter increments again.
  - Next state=RUN otherwise.
- Counters saturate at all-ones and never wrap.
- Simultaneous load_use and i_pc_sel_ex: redirect wins and no stall is counted.
- A reset asserted mid-MEM_WAIT or mid-REDIRECT returns immediately to RUN with counters cleared.
- Reset release is not a hazard; first cycle after release is RUN with default outputs.

Test Plan:
- Reset held 3 cycles then released, no hazards → all flushes 0 during reset; then o_pc_enable=1, all enables 1, o_state=0, counters 0.
- EX=lw x5 (rd_wren=1, wb_sel=01), ID=add x6,x5,x7 → one cycle of o_pc_enable=0, o_enable_if=0, o_reset_id=0; o_stall_cnt=1. Same with ID=lui x5 → no stall.
- EX=lw x0, ID uses x0 → no stall. EX=lw x5, ID=sw x5 as rs2 (opcode 0100011) → stall.
- i_pc_sel_ex=1 with load_use true in the same cycle → o_reset_if=0, o_reset_id=0, o_pc_enable=1; o_flush_cnt=1, o_stall_cnt=0; o_state=2 next cycle, then 0.
- i_lsu_busy high 4 cycles while i_pc_sel_ex=1 → 4 cycles all enables 0, o_memwait_cnt=4, o_state=1; on release one flush, o_flush_cnt=1.
- CNT_W=2, 5 load-use bubbles → o_stall_cnt stops at 3. Assert i_reset during MEM_WAIT → o_state=0 and counters 0 asynchronously.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: drives stall/flush for the PC and pipeline registers
// from load-use, EX-stage redirect and LSU-busy conditions, with saturating counters.
module hazard_ctrl #(
   parameter int         CNT_W       = 32,
   parameter logic [1:0] WB_SEL_LOAD = 2'b01
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [31:0]      i_instr_id,
   input  logic [31:0]      i_instr_ex,
   input  logic             i_rd_wren_ex,
   input  logic [1:0]       i_wb_sel_ex,
   input  logic             i_pc_sel_ex,
   input  logic             i_lsu_busy,
   output logic             o_pc_enable,
   output logic             o_enable_if,
   output logic             o_reset_if,
   output logic             o_enable_id,
   output logic             o_reset_id,
   output logic             o_enable_ex,
   output logic [1:0]       o_state,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt,
   output logic [CNT_W-1:0] o_memwait_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      REDIRECT = 2'd2
   } state_t;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;

   state_t           r_state;
   state_t           w_nextState;
   logic [CNT_W-1:0] r_stallCnt;
   logic [CNT_W-1:0] r_flushCnt;
   logic [CNT_W-1:0] r_waitCnt;

   logic [6:0] w_opId;
   logic [4:0] w_rs1Id;
   logic [4:0] w_rs2Id;
   logic [4:0] w_rdEx;
   logic       w_usesRs1;
   logic       w_usesRs2;
   logic       w_loadUse;
   logic       w_incStall;
   logic       w_incFlush;
   logic       w_incWait;
   logic       w_unused;

   assign w_opId   = i_instr_id[6:0];
   assign w_rs1Id  = i_instr_id[19:15];
   assign w_rs2Id  = i_instr_id[24:20];
   assign w_rdEx   = i_instr_ex[11:7];
   assign w_unused = ^{i_instr_id[31:25], i_instr_id[14:7], i_instr_ex[31:12], i_instr_ex[6:0]};

   assign w_usesRs1 = (w_opId != OP_LUI) && (w_opId != OP_AUIPC) && (w_opId != OP_JAL);
   assign w_usesRs2 = (w_opId == OP_R) || (w_opId == OP_S) || (w_opId == OP_B);

   assign w_loadUse = i_rd_wren_ex && (i_wb_sel_ex == WB_SEL_LOAD) && (w_rdEx != 5'd0) &&
                      ((w_usesRs1 && (w_rs1Id == w_rdEx)) || (w_usesRs2 && (w_rs2Id == w_rdEx)));

   // In REDIRECT the ID stage holds the flushed NOP, so a load-use match there is stale.
   always_comb begin
      o_pc_enable = 1'b1;
      o_enable_if = 1'b1;
      o_reset_if  = 1'b1;
      o_enable_id = 1'b1;
      o_reset_id  = 1'b1;
      o_enable_ex = 1'b1;
      w_nextState = RUN;
      w_incStall  = 1'b0;
      w_incFlush  = 1'b0;
      w_incWait   = 1'b0;
      if (i_reset) begin
         o_pc_enable = 1'b0;
         o_enable_if = 1'b0;
         o_reset_if  = 1'b0;
         o_enable_id = 1'b0;
         o_reset_id  = 1'b0;
         o_enable_ex = 1'b0;
      end else if (i_lsu_busy) begin
         o_pc_enable = 1'b0;
         o_enable_if = 1'b0;
         o_enable_id = 1'b0;
         o_enable_ex = 1'b0;
         w_nextState = MEM_WAIT;
         w_incWait   = 1'b1;
      end else if (i_pc_sel_ex) begin
         o_reset_if  = 1'b0;
         o_reset_id  = 1'b0;
         w_nextState = REDIRECT;
         w_incFlush  = 1'b1;
      end else if (w_loadUse && (r_state != REDIRECT)) begin
         o_pc_enable = 1'b0;
         o_enable_if = 1'b0;
         o_reset_id  = 1'b0;
         w_incStall  = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= RUN;
      else         r_state <= w_nextState;
   end

   // Counters hold at all-ones instead of wrapping.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_stallCnt <= '0;
         r_flushCnt <= '0;
         r_waitCnt  <= '0;
      end else begin
         if (w_incStall && (r_stallCnt != '1)) r_stallCnt <= r_stallCnt + 1'b1;
         if (w_incFlush && (r_flushCnt != '1)) r_flushCnt <= r_flushCnt + 1'b1;
         if (w_incWait  && (r_waitCnt  != '1)) r_waitCnt  <= r_waitCnt  + 1'b1;
      end
   end

   assign o_state       = r_state;
   assign o_stall_cnt   = r_stallCnt;
   assign o_flush_cnt   = r_flushCnt;
   assign o_memwait_cnt = r_waitCnt;

endmodule
